// File: rtl/pepelatz_fetch.sv
// rtl/pepelatz_fetch.sv - instruction prefetcher: ROM request FSM feeding a prefetch queue with redirect
module pepelatz_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_req,
    output logic [15:0]              rom_address,
    input  logic [15:0]              rom_data,
    input  logic                     rom_ready,
    output logic                     instr_valid,
    output logic [15:0]              instr_data,
    output logic [15:0]              instr_pc,
    input  logic                     instr_ready,
    input  logic                     jmp_valid,
    input  logic [15:0]              jmp_addr,
    output logic [$clog2(DEPTH):0]   fetch_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     pc, target;
    logic [CW-1:0]   count, count_next;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [15:0]     mem_data [DEPTH];
    logic [15:0]     mem_pc   [DEPTH];
    logic            push, pop;

    // A redirect suppresses both push and pop: the flush wins over everything.
    assign push       = (state_q == FETCH) && rom_ready && !jmp_valid;
    assign pop        = (count != '0) && instr_ready && !jmp_valid;
    assign count_next = jmp_valid ? '0 : count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (jmp_valid || count < FULL) state_d = FETCH;
            FETCH: begin
                if (jmp_valid)      state_d = rom_ready ? FETCH : DROP;
                else if (rom_ready) state_d = (count_next < FULL) ? FETCH : IDLE;
            end
            DROP:  if (rom_ready) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rom_req     = (state_q != IDLE);
        rom_address = pc;
        instr_valid = (count != '0);
        instr_data  = mem_data[rd_ptr];
        instr_pc    = mem_pc[rd_ptr];
        fetch_count = count;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= RESET_PC;
            target <= 16'h0000;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= 16'h0000;
                mem_pc[i]   <= 16'h0000;
            end
        end else begin
            count <= count_next;
            if (jmp_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    mem_data[wr_ptr] <= rom_data;
                    mem_pc[wr_ptr]   <= pc;
                    wr_ptr           <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
            // The address must stay put while a dropped request drains, so the target waits aside.
            case (state_q)
                IDLE: if (jmp_valid) pc <= jmp_addr;
                FETCH: begin
                    if (jmp_valid) begin
                        if (rom_ready) pc <= jmp_addr;
                        else           target <= jmp_addr;
                    end else if (rom_ready) begin
                        pc <= pc + 16'h0001;
                    end
                end
                DROP: begin
                    if (jmp_valid && rom_ready) pc <= jmp_addr;
                    else if (jmp_valid)         target <= jmp_addr;
                    else if (rom_ready)         pc <= target;
                end
                default: ;
            endcase
        end
    end
endmodule
